// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect
// from execute, and the valid/ready feed toward decode.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [31:0]       imem_resp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [31:0]       if_instr;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, single outstanding imem request,
// prefetch FIFO of {pc, instr} toward decode, redirect flush of stale fetches.
module fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]       fifo_instr_q [FIFO_DEPTH];

  logic              req_fire, push, pop;
  logic [ADDR_W-1:0] redir_aligned;

  assign redir_aligned = bus.redirect_pc & ~ADDR_W'(3);
  assign req_fire      = bus.imem_req_valid && bus.imem_req_ready;
  // A response racing a redirect belongs to the old path and is dropped.
  assign push          = (state_q == S_WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
  assign pop           = bus.if_valid && bus.if_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      fifo_instr_q[wr_ptr_q] <= bus.imem_resp_data;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      // Still waiting on memory means the in-flight word must be swallowed.
      state_d = (state_q != S_REQ && !bus.imem_resp_valid) ? S_FLUSH : S_REQ;
    end else begin
      case (state_q)
        S_REQ:   if (req_fire)            state_d = S_WAIT;
        S_WAIT:  if (bus.imem_resp_valid) state_d = S_REQ;
        S_FLUSH: if (bus.imem_resp_valid) state_d = S_REQ;
        default:                          state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    bus.imem_req_valid = reset && (state_q == S_REQ) && !bus.redirect_valid &&
                         (count_q < CNT_W'(FIFO_DEPTH));
    bus.imem_req_addr  = fetch_pc_q;
    bus.if_valid       = (count_q != '0);
    bus.if_pc          = fifo_pc_q[rd_ptr_q];
    bus.if_instr       = fifo_instr_q[rd_ptr_q];
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      req_pc_d   = fetch_pc_q;
    end
    if (bus.redirect_valid) begin
      fetch_pc_d = redir_aligned;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural imem with programmable
// latency, an expected-address model and a queue of expected decode entries.
module tb_fetch_unit;
  localparam int          AW  = 32;
  localparam logic [31:0] RPC = 32'h0;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_unit_if #(.ADDR_W(AW)) bus ();

  fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC), .FIFO_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        exp_q[$];
  logic [31:0] exp_addr;
  int          lat;
  bit          mem_busy;
  int          mem_timer;
  logic [31:0] mem_addr;
  bit          pend_live;
  bit          rd_on_resp;
  logic [31:0] rd_target;
  bit          rand_io;
  bit          saw_wrap;
  logic [31:0] last_fire;
  bit          arm_first;
  logic [31:0] first_addr;
  int          n_pops;

  function automatic logic [31:0] mem_f(logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // One clock: observe/score at negedge, drive next-cycle inputs after posedge.
  task automatic cycle();
    ent_t e;
    @(negedge clock);
    chk("if_valid", bus.if_valid, exp_q.size() != 0);
    if (mem_busy)           chk("one_outstanding", bus.imem_req_valid, 1'b0);
    if (bus.redirect_valid) chk("no_req_on_redir", bus.imem_req_valid, 1'b0);
    if (bus.if_valid && bus.if_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("if_pc", bus.if_pc, e.pc);
      chk("if_instr", bus.if_instr, e.instr);
      n_pops++;
    end
    if (bus.imem_resp_valid) begin
      if (!bus.redirect_valid && pend_live)
        exp_q.push_back('{pc: mem_addr, instr: mem_f(mem_addr)});
      mem_busy = 1'b0;
    end
    if (bus.redirect_valid) begin
      exp_q.delete();
      pend_live = 1'b0;
      exp_addr  = {bus.redirect_pc[31:2], 2'b00};
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      chk("req_addr", bus.imem_req_addr, exp_addr);
      if (bus.imem_req_addr == 32'h0 && last_fire == 32'hFFFF_FFFC) saw_wrap = 1'b1;
      if (arm_first) begin
        first_addr = bus.imem_req_addr;
        arm_first  = 1'b0;
      end
      last_fire = bus.imem_req_addr;
      exp_addr  = exp_addr + 32'd4;
      mem_busy  = 1'b1;
      mem_timer = lat;
      mem_addr  = bus.imem_req_addr;
      pend_live = 1'b1;
    end
    @(posedge clock);
    #1;
    bus.imem_resp_valid = 1'b0;
    if (mem_busy && mem_timer > 0) begin
      mem_timer--;
      if (mem_timer == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_f(mem_addr);
      end
    end
    bus.redirect_valid = 1'b0;
    if (rd_on_resp && bus.imem_resp_valid) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = rd_target;
      rd_on_resp         = 1'b0;
    end
    if (rand_io) begin
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      bus.if_ready       = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    reset               = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.if_ready        = 1'b1;
    exp_q.delete();
    exp_addr   = RPC;
    mem_busy   = 1'b0;
    mem_timer  = 0;
    pend_live  = 1'b0;
    rd_on_resp = 1'b0;
    rand_io    = 1'b0;
    #1;
    chk("rst_if_valid", bus.if_valid, 1'b0);
    chk("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk("rst_req_addr", bus.imem_req_addr, RPC);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("first_req_valid", bus.imem_req_valid, 1'b1);
  endtask

  initial begin
    int pops_before;
    int n;
    lat = 1; last_fire = '0; saw_wrap = 1'b0; arm_first = 1'b0;
    first_addr = '1; n_pops = 0; rd_target = '0; mem_addr = '0;
    do_reset();

    // Streaming with a 1-cycle memory, then random stalls on both sides
    repeat (16) cycle();
    rand_io = 1'b1;
    repeat (40) cycle();
    rand_io = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b1;
    repeat (10) cycle();

    // Decode stalled: FIFO fills to 4, fetch stops, then drains and resumes at 0x10
    do_reset();
    bus.if_ready = 1'b0;
    repeat (20) cycle();
    chk("t2_full_noreq", bus.imem_req_valid, 1'b0);
    chk("t2_full_valid", bus.if_valid, 1'b1);
    bus.if_ready = 1'b1;
    arm_first    = 1'b1;
    pops_before  = n_pops;
    repeat (4) cycle();
    chk("t2_pops", n_pops - pops_before, 4);
    repeat (8) cycle();
    chk("t2_resume_addr", first_addr, 32'h10);

    // Redirect during WAIT; old response lands 3 cycles later and is dropped
    lat = 4;
    n = 0;
    while (!mem_busy && n < 10) begin cycle(); n++; end
    chk("t3_got_req", mem_busy, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    arm_first          = 1'b1;
    repeat (12) cycle();
    chk("t3_next_addr", first_addr, 32'h100);
    lat = 1;
    repeat (6) cycle();

    // Redirect coincident with the response, FIFO non-empty beforehand
    bus.if_ready = 1'b0;
    repeat (4) cycle();
    chk("t4_pre_valid", bus.if_valid, 1'b1);
    rd_target  = 32'h203;
    rd_on_resp = 1'b1;
    n = 0;
    while (rd_on_resp && n < 10) begin cycle(); n++; end
    chk("t4_armed", rd_on_resp, 1'b0);
    arm_first = 1'b1;
    cycle();
    chk("t4_empty", bus.if_valid, 1'b0);
    bus.if_ready = 1'b1;
    repeat (8) cycle();
    chk("t4_next_addr", first_addr, 32'h200);

    // Asynchronous reset mid-WAIT with two entries buffered
    bus.if_ready = 1'b0;
    n = 0;
    while (!(exp_q.size() == 2 && mem_busy) && n < 20) begin cycle(); n++; end
    chk("t5_pre_valid", bus.if_valid, 1'b1);
    chk("t5_pre_busy", mem_busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_if_valid", bus.if_valid, 1'b0);
    chk("t5_req_valid", bus.imem_req_valid, 1'b0);
    do_reset();
    arm_first = 1'b1;
    repeat (6) cycle();
    chk("t5_first_addr", first_addr, RPC);

    // PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    saw_wrap           = 1'b0;
    repeat (10) cycle();
    chk("t6_wrap", saw_wrap, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
endmodule
